mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of EX. Registers the EX/MEM bus, extracts and extends load data
//  from data SRAM read data, and selects the writeback value. Drives MEM/WB bus and MEM->ID forwarding bus.
//  Buffers SRAM read data when MEM is stalled, since SRAM rdata is valid only in the cycle after the request.
// PARAMETERS
//  EX_TO_MEM_WD  76  {pc[75:44],ram_en[43],ram_wen[42:39],sel_rf_res[38],rf_we[37],rf_waddr[36:32],ex_result[31:0]}
//  MEM_TO_WB_WD  70  {pc[69:38],rf_we[37],rf_waddr[36:32],rf_wdata[31:0]}
//  MEM_TO_RF_WD  38  {rf_we[37],rf_waddr[36:32],rf_wdata[31:0]}
//  LOAD_W        5   {lb,lbu,lh,lhu,lw}, one-hot or zero
//  STALL_W       6   stall vector; bit i=1 (Stop) freezes stage i
// PORTS
//  clk              in   1             clock, all state on posedge
//  resetn           in   1             asynchronous, active-low reset
//  stall            in   STALL_W       stall[3]=EX/MEM reg hold, stall[4]=MEM/WB hold
//  ex_to_mem_bus    in   EX_TO_MEM_WD  EX results, layout above
//  ex_load_bus      in   LOAD_W        load type of the EX instruction
//  data_sram_rdata  in   32            SRAM read data, valid in the cycle after the EX request
//  mem_to_wb_bus    out  MEM_TO_WB_WD  to WB pipeline register
//  mem_to_rf_bus    out  MEM_TO_RF_WD  forwarding to ID, same cycle as mem_to_wb_bus
//  mem_load_active  out  1             MEM holds a load (sel_rf_res=1); used by ID load-use detection
// BEHAVIOUR
//  Reset (resetn=0, asynchronous):
//   - Clears pipeline regs, load regs, rdata_buf, buf_valid.
//   - Every output is 0 while reset is held.
//  Pipeline register, per posedge, in priority order:
//   1. stall[3]=1 and stall[4]=0: load bubble (all regs 0).
//   2. stall[3]=0: capture ex_to_mem_bus and ex_load_bus.
//   3. Otherwise: hold.
//  Read-data buffer (rdata_buf, buf_valid):
//   - Set: posedge where stall[4]=1, buf_valid=0 and the MEM instruction is a load.
//     rdata_buf <= data_sram_rdata, buf_valid <= 1.
//   - Clear: any posedge where the stage captures or bubbles; buf_valid <= 0.
//   - Clear takes priority over set.
//   - Source data: ld_src = buf_valid ? rdata_buf : data_sram_rdata.
//  Extraction, with a = ex_result[1:0]:
//   - lb/lbu: byte a. lb sign-extends, lbu zero-extends.
//   - lh/lhu: halfword a[1]; a[0] is ignored. lh sign-extends, lhu zero-extends.
//   - lw: ld_src as-is; a is ignored.
//   - No load bit set: ld_src as-is.
//  Writeback value: rf_wdata = sel_rf_res ? extracted : ex_result.
//  Other outputs:
//   - rf_we and rf_waddr pass through from the register. rf_waddr=0 is not masked here.
//   - Store instructions reach this stage with rf_we=0. ram_en and ram_wen are consumed by nothing here.
//   - Outputs are combinational from registers, buffer and rdata. Latency is one cycle EX->MEM.
// TESTING
//  1. lb, a=2'b01, rdata=0x1234_80FF -> rf_wdata=0xFFFF_FF80. Same with lbu -> 0x0000_0080.
//  2. lh, a=2'b10, rdata=0x8001_7FFF -> 0xFFFF_8001. lhu, a=2'b00 -> 0x0000_7FFF.
//  3. lw in MEM, stall[4]=1 for 3 cycles, rdata 0xDEAD_BEEF then 0x0 -> rf_wdata holds 0xDEAD_BEEF; buf clears on advance.
//  4. stall[3]=1, stall[4]=0 with valid EX bus -> next cycle rf_we=0, rf_wdata=0, mem_load_active=0.
//  5. ALU op rf_we=1, waddr=5, ex_result=0x0000_1234 -> both output buses carry {1,5,0x1234} one cycle after capture.
//  6. resetn=0 mid-cycle during a held load -> all outputs 0 before the next edge; first post-reset edge captures normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load data extraction and writeback select.
// Holds SRAM read data across MEM stalls, since rdata is only valid one cycle.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 76,
   parameter int MEM_TO_WB_WD = 70,
   parameter int MEM_TO_RF_WD = 38,
   parameter int LOAD_W       = 5,
   parameter int STALL_W      = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_W-1:0]      stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [LOAD_W-1:0]       ex_load_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
   output logic                    mem_load_active
);

   logic [EX_TO_MEM_WD-1:0] ex_mem_q;
   logic [LOAD_W-1:0]       load_q;
   logic [31:0]             rdata_buf;
   logic                    buf_valid;

   logic        capture;
   logic        bubble;
   logic        hold;

   logic [31:0] pc;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;
   logic [1:0]  addr_lo;

   logic [31:0] ld_src;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic [31:0] rf_wdata;

   logic        unused_ok;

   assign capture = ~stall[3];
   assign bubble  = stall[3] & ~stall[4];
   assign hold    = stall[3] & stall[4];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ex_mem_q <= '0;
         load_q   <= '0;
      end else if (bubble) begin
         ex_mem_q <= '0;
         load_q   <= '0;
      end else if (capture) begin
         ex_mem_q <= ex_to_mem_bus;
         load_q   <= ex_load_bus;
      end
   end

   // Latch rdata on the first stalled edge; later rdata is no longer ours.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf <= '0;
         buf_valid <= 1'b0;
      end else if (!hold) begin
         buf_valid <= 1'b0;
      end else if (stall[4] && !buf_valid && sel_rf_res) begin
         rdata_buf <= data_sram_rdata;
         buf_valid <= 1'b1;
      end
   end

   assign pc         = ex_mem_q[75:44];
   assign sel_rf_res = ex_mem_q[38];
   assign rf_we      = ex_mem_q[37];
   assign rf_waddr   = ex_mem_q[36:32];
   assign ex_result  = ex_mem_q[31:0];
   assign addr_lo    = ex_result[1:0];

   assign ld_src  = buf_valid ? rdata_buf : data_sram_rdata;
   assign ld_byte = ld_src[{addr_lo, 3'b000} +: 8];
   assign ld_half = addr_lo[1] ? ld_src[31:16] : ld_src[15:0];

   always_comb begin
      ld_val = ld_src;
      unique case (1'b1)
         load_q[4]: ld_val = {{24{ld_byte[7]}}, ld_byte};
         load_q[3]: ld_val = {24'h0, ld_byte};
         load_q[2]: ld_val = {{16{ld_half[15]}}, ld_half};
         load_q[1]: ld_val = {16'h0, ld_half};
         load_q[0]: ld_val = ld_src;
         default:   ld_val = ld_src;
      endcase
   end

   assign rf_wdata = sel_rf_res ? ld_val : ex_result;

   assign mem_to_rf_bus   = {rf_we, rf_waddr, rf_wdata};
   assign mem_to_wb_bus   = {pc, mem_to_rf_bus};
   assign mem_load_active = sel_rf_res;

   // ram_en/ram_wen were consumed by EX; only the MEM/WB stall bits matter here.
   assign unused_ok = ^{ex_mem_q[43:39], stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, stall buffering,
// bubbles, ALU passthrough and asynchronous reset.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic [5:0]  stall;
   logic [75:0] ex_to_mem_bus;
   logic [4:0]  ex_load_bus;
   logic [31:0] data_sram_rdata;
   logic [69:0] mem_to_wb_bus;
   logic [37:0] mem_to_rf_bus;
   logic        mem_load_active;

   int n_tests;
   int n_fail;

   localparam logic [4:0] LB  = 5'b10000;
   localparam logic [4:0] LBU = 5'b01000;
   localparam logic [4:0] LH  = 5'b00100;
   localparam logic [4:0] LHU = 5'b00010;
   localparam logic [4:0] LW  = 5'b00001;
   localparam logic [4:0] NOL = 5'b00000;

   localparam logic [5:0] RUN  = 6'b000000;
   localparam logic [5:0] HOLD = 6'b011111;
   localparam logic [5:0] BUBL = 6'b001111;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_load_bus     (ex_load_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_rf_bus   (mem_to_rf_bus),
      .mem_load_active (mem_load_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [69:0] got,
                      input logic [69:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [75:0] mk(input logic [31:0] pc,
                                      input logic ld,
                                      input logic we,
                                      input logic [4:0] wa,
                                      input logic [31:0] res);
      return {pc, ld, 4'b0000, ld, we, wa, res};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [75:0] b, input logic [4:0] l);
      ex_to_mem_bus = b;
      ex_load_bus   = l;
      step();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      resetn          = 1'b0;
      stall           = RUN;
      ex_to_mem_bus   = mk(32'h8000_0000, 1'b0, 1'b1, 5'd4, 32'hAAAA_5555);
      ex_load_bus     = NOL;
      data_sram_rdata = 32'hFFFF_FFFF;

      #2;
      chk("rst_wb", 70'(mem_to_wb_bus), 70'h0);
      chk("rst_rf", 70'(mem_to_rf_bus), 70'h0);
      chk("rst_la", 70'(mem_load_active), 70'h0);
      step();
      chk("rst_wb_clk", 70'(mem_to_wb_bus), 70'h0);
      resetn = 1'b1;

      // byte loads
      issue(mk(32'h100, 1'b1, 1'b1, 5'd3, 32'h0000_1001), LB);
      data_sram_rdata = 32'h1234_80FF;
      #1;
      chk("lb_a1", 70'(mem_to_rf_bus[31:0]), 70'hFFFF_FF80);
      chk("lb_la", 70'(mem_load_active), 70'h1);
      issue(mk(32'h104, 1'b1, 1'b1, 5'd3, 32'h0000_1001), LBU);
      data_sram_rdata = 32'h1234_80FF;
      #1;
      chk("lbu_a1", 70'(mem_to_rf_bus[31:0]), 70'h0000_0080);

      // halfword loads
      issue(mk(32'h108, 1'b1, 1'b1, 5'd6, 32'h0000_2002), LH);
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("lh_a2", 70'(mem_to_rf_bus[31:0]), 70'hFFFF_8001);
      issue(mk(32'h10C, 1'b1, 1'b1, 5'd6, 32'h0000_2000), LHU);
      data_sram_rdata = 32'h8001_7FFF;
      #1;
      chk("lhu_a0", 70'(mem_to_rf_bus[31:0]), 70'h0000_7FFF);

      // lw held by a MEM stall: buffered rdata must survive rdata changing
      issue(mk(32'h110, 1'b1, 1'b1, 5'd7, 32'h0000_3003), LW);
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("lw_first", 70'(mem_to_rf_bus[31:0]), 70'hDEAD_BEEF);
      stall         = HOLD;
      ex_to_mem_bus = mk(32'h114, 1'b0, 1'b1, 5'd8, 32'h0000_0777);
      ex_load_bus   = NOL;
      for (int i = 0; i < 3; i++) begin
         step();
         data_sram_rdata = 32'h0;
         #1;
         chk($sformatf("lw_hold%0d", i), 70'(mem_to_rf_bus), {32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF});
      end
      stall = RUN;
      step();
      chk("adv_alu", 70'(mem_to_rf_bus), {32'h0, 1'b1, 5'd8, 32'h0000_0777});
      chk("adv_la", 70'(mem_load_active), 70'h0);
      issue(mk(32'h118, 1'b1, 1'b1, 5'd9, 32'h0000_3000), LW);
      data_sram_rdata = 32'h1111_2222;
      #1;
      chk("buf_clr", 70'(mem_to_rf_bus[31:0]), 70'h1111_2222);

      // ALU op on both buses
      issue(mk(32'h8000_0010, 1'b0, 1'b1, 5'd5, 32'h0000_1234), NOL);
      chk("alu_wb", 70'(mem_to_wb_bus), {32'h8000_0010, 1'b1, 5'd5, 32'h0000_1234});
      chk("alu_rf", 70'(mem_to_rf_bus), {32'h0, 1'b1, 5'd5, 32'h0000_1234});

      // load bubble
      stall = BUBL;
      issue(mk(32'h120, 1'b1, 1'b1, 5'd10, 32'h0000_4000), LW);
      data_sram_rdata = 32'h5555_AAAA;
      #1;
      chk("bub_we", 70'(mem_to_rf_bus[37]), 70'h0);
      chk("bub_wd", 70'(mem_to_rf_bus[31:0]), 70'h0);
      chk("bub_la", 70'(mem_load_active), 70'h0);
      chk("bub_wb", 70'(mem_to_wb_bus), 70'h0);

      // async reset mid-cycle during a held load
      stall = RUN;
      issue(mk(32'h124, 1'b1, 1'b1, 5'd11, 32'h0000_5000), LW);
      data_sram_rdata = 32'hCAFE_F00D;
      stall = HOLD;
      ex_to_mem_bus = mk(32'h128, 1'b0, 1'b1, 5'd9, 32'h0000_9999);
      ex_load_bus   = NOL;
      step();
      data_sram_rdata = 32'h0;
      #1;
      chk("pre_rst", 70'(mem_to_rf_bus[31:0]), 70'hCAFE_F00D);
      #1;
      resetn = 1'b0;
      #1;
      chk("mid_rst_wb", 70'(mem_to_wb_bus), 70'h0);
      chk("mid_rst_rf", 70'(mem_to_rf_bus), 70'h0);
      chk("mid_rst_la", 70'(mem_load_active), 70'h0);
      #1;
      resetn = 1'b1;
      stall  = RUN;
      step();
      chk("post_rst", 70'(mem_to_wb_bus), {32'h128, 1'b1, 5'd9, 32'h0000_9999});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
